// File: rtl/deca_vip_status_pkg.sv
// Shared types and constants for the DECA VIP status poller.
package deca_vip_status_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StUpdate
    } poll_state_e;

    localparam logic [1:0] STATUS_ADDR = 2'd0;

endpackage

// File: rtl/deca_vip_edge_detect.sv
// Registered per-bit rise/fall detector; pulses last one cycle after each strobe.
module deca_vip_edge_detect #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         strobe_i,
    input  logic         first_i,
    input  logic [W-1:0] old_i,
    input  logic [W-1:0] new_i,
    output logic [W-1:0] rise_o,
    output logic [W-1:0] fall_o,
    output logic         change_o
);

    logic [W-1:0] rise_q, rise_d;
    logic [W-1:0] fall_q, fall_d;
    logic         change_q, change_d;

    always_comb begin
        rise_d = '0;
        fall_d = '0;
        // The first sample has no meaningful predecessor, so it never reports edges.
        if (strobe_i && !first_i) begin
            rise_d = new_i & ~old_i;
            fall_d = ~new_i & old_i;
        end
        change_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_q   <= '0;
            fall_q   <= '0;
            change_q <= 1'b0;
        end else begin
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            change_q <= change_d;
        end
    end

    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign change_o = change_q;

endmodule

// File: rtl/deca_vip_status_poller.sv
// Periodic Avalon-MM status register poller with edge reporting and a sticky
// read-timeout flag.
module deca_vip_status_poller
    import deca_vip_status_pkg::*;
#(
    parameter int unsigned POLL_PERIOD = 1000,
    parameter int unsigned STATUS_W    = 4,
    parameter int unsigned RD_TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                poll_now,
    output logic [1:0]          avm_address,
    output logic                avm_read,
    input  logic                avm_waitrequest,
    input  logic                avm_readdatavalid,
    input  logic [31:0]         avm_readdata,
    output logic [STATUS_W-1:0] status,
    output logic                status_valid,
    output logic [STATUS_W-1:0] rise,
    output logic [STATUS_W-1:0] fall,
    output logic                change,
    output logic                timeout_err
);

    localparam int unsigned PerW = $clog2(POLL_PERIOD);
    localparam int unsigned TmoW = $clog2(RD_TIMEOUT + 1);
    localparam logic [PerW-1:0] PeriodLast  = PerW'(POLL_PERIOD - 1);
    localparam logic [TmoW-1:0] TimeoutLast = TmoW'(RD_TIMEOUT - 1);

    poll_state_e         state_q, state_d;
    logic [PerW-1:0]     cnt_q, cnt_d;
    logic [TmoW-1:0]     tmo_q, tmo_d;
    logic [STATUS_W-1:0] sample_q, sample_d;
    logic [STATUS_W-1:0] status_q, status_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                update;
    logic                unused_readdata;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        sample_d = sample_q;
        status_d = status_q;
        valid_d  = valid_q;
        err_d    = err_q;

        // Counts through the whole transaction so spacing is start-to-start;
        // saturates so an overlong transaction starts the next poll on return to IDLE.
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q != PeriodLast) begin
            cnt_d = cnt_q + PerW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if ((enable && cnt_q == PeriodLast) || poll_now) begin
                    state_d = StReq;
                    cnt_d   = '0;
                end
            end
            StReq: begin
                if (!avm_waitrequest) begin
                    state_d = StWait;
                    tmo_d   = '0;
                end
            end
            StWait: begin
                if (avm_readdatavalid) begin
                    sample_d = avm_readdata[STATUS_W-1:0];
                    state_d  = StUpdate;
                end else if (tmo_q == TimeoutLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StUpdate: begin
                status_d = sample_q;
                valid_d  = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            tmo_q    <= '0;
            sample_q <= '0;
            status_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            sample_q <= sample_d;
            status_q <= status_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign update = (state_q == StUpdate);

    deca_vip_edge_detect #(
        .W(STATUS_W)
    ) u_edge (
        .clk     (clk),
        .reset   (reset),
        .strobe_i(update),
        .first_i (!valid_q),
        .old_i   (status_q),
        .new_i   (sample_q),
        .rise_o  (rise),
        .fall_o  (fall),
        .change_o(change)
    );

    assign avm_address     = STATUS_ADDR;
    assign avm_read        = (state_q == StReq);
    assign status          = status_q;
    assign status_valid    = valid_q;
    assign timeout_err     = err_q;
    assign unused_readdata = ^avm_readdata;

endmodule

// File: tb/tb_deca_vip_status_poller.sv
// Directed plus randomized bench for deca_vip_status_poller with an Avalon slave model.
module tb_deca_vip_status_poller;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        poll_now;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;
    logic [31:0] avm_readdata;
    logic [3:0]  status;
    logic        status_valid;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic        change;
    logic        timeout_err;

    deca_vip_status_poller #(
        .POLL_PERIOD(8),
        .STATUS_W   (4),
        .RD_TIMEOUT (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .poll_now         (poll_now),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid),
        .avm_readdata     (avm_readdata),
        .status           (status),
        .status_valid     (status_valid),
        .rise             (rise),
        .fall             (fall),
        .change           (change),
        .timeout_err      (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Slave configuration (written by the main sequence) and observation counters.
    logic [3:0] slave_data = 4'h0;
    int stall_next = 0;
    int lat_next   = 1;   // 0 = never respond
    int accepts    = 0;
    int cyc        = 0;
    int rd_hi_cnt  = 0;
    int starts[$];

    // Reference model state.
    logic [3:0] model_status = 4'h0;
    logic       model_valid  = 1'b0;
    logic       model_err    = 1'b0;
    int         last_start   = 0;

    // Monitor: cycle count, read starts and read-high cycles, sampled after the edge.
    initial begin
        logic rd_prev;
        rd_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (avm_read && !rd_prev) starts.push_back(cyc);
            if (avm_read) rd_hi_cnt++;
            rd_prev = avm_read;
        end
    end

    // Avalon slave: configurable stall, fixed latency, random noise when idle.
    initial begin
        logic        sl_prev;
        logic [31:0] tmp;
        int          stall_left;
        int          resp_cnt;
        sl_prev    = 1'b0;
        stall_left = 0;
        resp_cnt   = 0;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        forever begin
            @(negedge clk);
            avm_readdatavalid = 1'b0;
            avm_readdata      = $urandom;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    tmp = $urandom;
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = {tmp[31:4], slave_data};
                end
            end
            if (avm_read) begin
                if (!sl_prev) stall_left = stall_next;
                if (stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    avm_waitrequest = 1'b0;
                    accepts++;
                    resp_cnt = lat_next;
                end
            end else begin
                avm_waitrequest = 1'($urandom_range(0, 1));
            end
            sl_prev = avm_read;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_start(output int s);
        logic got;
        got = 1'b0;
        s   = cyc;
        for (int i = 0; i < 100 && !got; i++) begin
            if (starts.size() > 0) begin
                s   = starts.pop_front();
                got = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        chk("read_start_seen", {31'b0, got}, 32'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_read"}, {31'b0, avm_read}, 32'd0);
        chk({tag, "_addr"}, {30'b0, avm_address}, 32'd0);
        chk({tag, "_status"}, {28'b0, status}, 32'd0);
        chk({tag, "_valid"}, {31'b0, status_valid}, 32'd0);
        chk({tag, "_rise"}, {28'b0, rise}, 32'd0);
        chk({tag, "_fall"}, {28'b0, fall}, 32'd0);
        chk({tag, "_change"}, {31'b0, change}, 32'd0);
        chk({tag, "_tmo"}, {31'b0, timeout_err}, 32'd0);
    endtask

    // One poll: gap = expected start-to-start distance (0 = unchecked),
    // kick = start via poll_now, pn_wait = pulse poll_now during WAIT.
    task automatic do_poll(input logic [3:0] d, input int stall, input int lat, input int gap,
                           input bit kick, input bit pn_wait);
        int s, hi0, acc0;
        logic [3:0] er, ef;
        slave_data = d;
        stall_next = stall;
        lat_next   = lat;
        hi0  = rd_hi_cnt;
        acc0 = accepts;
        if (kick) begin
            poll_now = 1'b1;
            @(negedge clk);
            poll_now = 1'b0;
        end
        wait_start(s);
        if (gap > 0) chk("start_gap", s - last_start, gap);
        last_start = s;
        chk("address", {30'b0, avm_address}, 32'd0);
        if (pn_wait) begin
            wait_cyc(s + stall + 1);
            poll_now = 1'b1;
            @(negedge clk);
            poll_now = 1'b0;
        end
        if (lat == 0) begin
            wait_cyc(s + stall + 16);
            chk("tmo_before_limit", {31'b0, timeout_err}, {31'b0, model_err});
            wait_cyc(s + stall + 17);
            model_err = 1'b1;
            chk("tmo_set", {31'b0, timeout_err}, 32'd1);
            chk("tmo_status_kept", {28'b0, status}, {28'b0, model_status});
            chk("tmo_no_change", {31'b0, change}, 32'd0);
        end else begin
            wait_cyc(s + stall + lat + 2);
            er = model_valid ? (d & ~model_status) : 4'h0;
            ef = model_valid ? (~d & model_status) : 4'h0;
            model_status = d;
            model_valid  = 1'b1;
            chk("rise", {28'b0, rise}, {28'b0, er});
            chk("fall", {28'b0, fall}, {28'b0, ef});
            chk("change", {31'b0, change}, {31'b0, (er | ef) != 4'h0});
            chk("status", {28'b0, status}, {28'b0, model_status});
            chk("status_valid", {31'b0, status_valid}, 32'd1);
            chk("tmo_sticky", {31'b0, timeout_err}, {31'b0, model_err});
            chk("read_hi_cycles", rd_hi_cnt - hi0, stall + 1);
            chk("accepts", accepts - acc0, 1);
            @(negedge clk);
            chk("rise_one_cycle", {28'b0, rise}, 32'd0);
            chk("fall_one_cycle", {28'b0, fall}, 32'd0);
            chk("change_one_cycle", {31'b0, change}, 32'd0);
        end
    endtask

    initial begin
        int s;
        reset    = 1'b1;
        enable   = 1'b0;
        poll_now = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");

        // Periodic polling from reset release; first read loads status silently.
        enable = 1'b1;
        reset  = 1'b0;
        last_start = cyc;
        do_poll(4'h5, 0, 1, 8, 1'b0, 1'b0);
        do_poll(4'h6, 0, 1, 8, 1'b0, 1'b0);
        do_poll(4'h9, 3, 1, 8, 1'b0, 1'b0);

        // Missing readdatavalid, then the next poll starts on the first IDLE cycle.
        do_poll(4'hf, 0, 0, 8, 1'b0, 1'b0);
        do_poll(4'h3, 0, 1, 18, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            do_poll(4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(1, 2), 8,
                    1'b0, 1'b0);
        end

        // Polling disabled: only poll_now in IDLE starts a read.
        enable = 1'b0;
        repeat (20) @(negedge clk);
        chk("disabled_no_reads", starts.size(), 0);
        do_poll(4'hc, 0, 2, 0, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        chk("poll_now_in_wait_ignored", starts.size(), 0);

        // Reset in WAIT: immediate reset state, late response ignored, restart timing.
        enable     = 1'b1;
        slave_data = 4'ha;
        stall_next = 0;
        lat_next   = 3;
        wait_start(s);
        wait_cyc(s + 1);
        reset = 1'b1;
        #1;
        chk_reset_state("reset_in_wait");
        model_status = 4'h0;
        model_valid  = 1'b0;
        model_err    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        last_start = cyc;
        wait_cyc(s + 4);
        chk("late_valid_ignored", {31'b0, status_valid}, 32'd0);
        chk("late_status_ignored", {28'b0, status}, 32'd0);
        do_poll(4'h7, 1, 1, 8, 1'b0, 1'b0);
        do_poll(4'h2, 0, 2, 8, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/deca_vip_status_poller.md
DECA_VIP_STATUS_POLLER -- requirements
Module: deca_vip_status_poller

Interface
REQ-001 Parameter POLL_PERIOD, default 1000; cycles between poll starts, measured start-to-start; legal range 8..65535.
REQ-002 Parameter STATUS_W, default 4; number of low readdata bits treated as status; legal range 1..32.
REQ-003 Parameter RD_TIMEOUT, default 16; maximum cycles to wait for readdatavalid after read acceptance.
REQ-004 Ports are one per line, clock and reset first:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; 1 = periodic polling runs.
- poll_now  in  1  single-cycle request for an immediate poll.
- avm_address  out  2  Avalon-MM word address; constant 0.
- avm_read  out  1  Avalon-MM read strobe.
- avm_waitrequest  in  1  slave stall.
- avm_readdatavalid  in  1  read data strobe.
- avm_readdata  in  32  read data.
- status  out  STATUS_W  last good sampled status.
- status_valid  out  1  set after the first good read.
- rise  out  STATUS_W  one-cycle pulse per bit that went 0->1.
- fall  out  STATUS_W  one-cycle pulse per bit that went 1->0.
- change  out  1  one-cycle pulse; OR of rise and fall.
- timeout_err  out  1  sticky flag; cleared by reset only.

Function
REQ-005 FSM states: IDLE, REQ, WAIT, UPDATE.
REQ-006 IDLE: period counter increments every cycle while enable=1; the FSM goes to REQ when the counter reaches POLL_PERIOD-1 or when poll_now=1. The counter clears when a poll starts.
REQ-007 With enable=0 the counter holds at 0 and only poll_now starts a poll.
REQ-008 REQ: avm_read=1 and avm_address=0. Hold both until a cycle with avm_waitrequest=0, then go to WAIT.
REQ-009 avm_read is 0 in every state other than REQ; at most one read is outstanding.
REQ-010 WAIT: on avm_readdatavalid=1, capture avm_readdata[STATUS_W-1:0] and go to UPDATE. avm_readdatavalid may arrive in the first WAIT cycle, giving latency 1 from acceptance.
REQ-011 WAIT timeout: if RD_TIMEOUT cycles pass without avm_readdatavalid, set timeout_err, leave status unchanged, and return to IDLE.
REQ-012 UPDATE (one cycle):
- rise = new & ~status; fall = ~new & status; change = |(rise|fall).
- status <= new; status_valid <= 1.
- Return to IDLE.
REQ-013 The first good read after reset produces no rise, fall or change pulses; it only loads status and sets status_valid.
REQ-014 rise, fall and change are registered and high for exactly one cycle, the cycle after UPDATE.
REQ-015 poll_now asserted outside IDLE is ignored, not queued.
REQ-016 Dropping enable mid-poll does not abort the poll; the poll completes normally.
REQ-017 avm_readdatavalid arriving outside WAIT is ignored.
REQ-018 Poll start-to-start spacing equals POLL_PERIOD provided each transaction completes in fewer than POLL_PERIOD cycles; otherwise the next poll starts on the first IDLE cycle.

Reset
REQ-019 Asynchronous reset returns the block to its reset state, including mid-transaction:
- State = IDLE; counter = 0.
- avm_read = 0; avm_address = 0.
- status = 0; status_valid = 0.
- rise = 0; fall = 0; change = 0; timeout_err = 0.
REQ-020 After reset deasserts, the first poll starts POLL_PERIOD cycles later when enable=1.

Structure
REQ-021 A shared package deca_vip_status_pkg holds the FSM state enum and the constant STATUS_ADDR=0.
REQ-022 One sub-module, deca_vip_edge_detect, computes the registered rise/fall/change outputs from the old and new values plus a first-sample flag.
REQ-023 All other logic sits in a single clocked process plus combinational next-state logic.

Verification
REQ-024 The bench covers these directed scenarios:
- POLL_PERIOD=8, enable=1, slave has zero waitrequest and latency 1 -> avm_read pulses every 8 cycles; first read of 0x5 gives status=0x5, status_valid=1, change=0.
- Status input changes from 0x5 to 0x6 -> next poll gives rise=0x2, fall=0x1, change=1, each for exactly one cycle.
- Slave holds waitrequest for 3 cycles -> avm_read stays high for 4 cycles and the read is accepted once; status updates correctly.
- No readdatavalid for RD_TIMEOUT=16 cycles -> timeout_err=1 and stays set; status unchanged; the next poll proceeds.
- enable=0, then poll_now pulsed in IDLE -> exactly one read; poll_now pulsed in WAIT -> no extra read.
- Reset asserted in WAIT -> all outputs return to reset values at once; a later readdatavalid is ignored; polling restarts after POLL_PERIOD cycles.
